// File: rtl/led_pkg.sv
// Shared definitions for the LED trail fader: channel count, pattern type, counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package led_pkg;

  // Number of LED channels driven by one fader.
  localparam int LED_COUNT = 8;

  // One bit per LED, as produced by the shifter.
  typedef logic [LED_COUNT-1:0] led_vec_t;

  // Width of a counter that runs 0..div-1. A divide-by-one counter still
  // gets one bit so the register and its compare stay well formed.
  function automatic int cnt_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness register with load/saturating decay, optional gamma, PWM compare.
// Latency: load -> led_out 2 edges (3 with LED_TRAIL_GAMMA_EN defined, extra register on the level).
// Backpressure: none; free-running, the output is recomputed every clock.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         registered input bit for this LED; forces full brightness
//   decay_tick   shared one-cycle strobe, steps brightness down when not loading
//   enable       0 forces the output dark without touching the brightness
//   pwm_cnt      shared free-running PWM ramp
//   led_out      registered PWM drive for this LED
//
// Optional macro LED_TRAIL_GAMMA_EN: level = (b*b) >> PWM_BITS (full scale kept at
// full scale), registered, adding one edge of latency.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                decay_tick,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] bright;
  logic [PWM_BITS-1:0] level;

  // A lit input always wins over a decay step landing in the same cycle.
  // The decay compares before subtracting so the level floors at zero
  // instead of wrapping back to a bright value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright <= '0;
    end else if (load) begin
      bright <= LVL_MAX;
    end else if (decay_tick) begin
      bright <= (bright > STEP) ? (bright - STEP) : '0;
    end
  end

`ifdef LED_TRAIL_GAMMA_EN
  // Square law over a double-width product; the top half is the perceptual
  // level. Full scale is pinned so a lit LED stays solidly on rather than
  // dropping one count short of constant drive.
  logic [2*PWM_BITS-1:0] bright_ext;
  logic [2*PWM_BITS-1:0] bright_sq;

  assign bright_ext = {{PWM_BITS{1'b0}}, bright};
  assign bright_sq  = bright_ext * bright_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (bright == LVL_MAX) begin
      level <= LVL_MAX;
    end else begin
      level <= PWM_BITS'(bright_sq >> PWM_BITS);
    end
  end
`else
  assign level = bright;
`endif

  // Level L is high for pwm_cnt 0..L, i.e. L+1 of every 2^PWM_BITS counts;
  // the explicit zero test keeps a dark LED fully off at pwm_cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= 1'b0;
    end else begin
      led_out <= enable & (level != '0) & (level >= pwm_cnt);
    end
  end

endmodule

// File: rtl/led_trail_fader.sv
// Turns the shifter's on/off LED pattern into PWM brightness with a decaying afterglow trail.
// Latency: led_in rise -> led_out on the 3rd edge after sampling (4th with LED_TRAIL_GAMMA_EN).
// Backpressure: none; led_in is sampled every clock and led_out is always driven.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset, clears all state immediately
//   led_in   LED pattern from the shifter, synchronous to clk
//   enable   1 drives the LEDs, 0 forces them dark (brightness keeps evolving)
//   led_out  registered PWM drive to the LED pins
//
// Optional macro LED_TRAIL_GAMMA_EN: square-law brightness per channel, one extra edge of latency.
module led_trail_fader
  import led_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int PWM_BITS   = 8,
  // Default gives roughly a 1 kHz PWM frame (2^8 counts per frame).
  parameter int PWM_DIV    = CLK_FREQ / 256_000,
  // Default gives roughly 512 decay steps per second.
  parameter int DECAY_DIV  = CLK_FREQ / 512,
  parameter int DECAY_STEP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] led_in,
  input  logic       enable,
  output logic [7:0] led_out
);

  localparam int PDIV_W = cnt_width(PWM_DIV);
  localparam int DDIV_W = cnt_width(DECAY_DIV);

  localparam logic [PDIV_W-1:0] PWM_DIV_LAST   = PDIV_W'(PWM_DIV - 1);
  localparam logic [DDIV_W-1:0] DECAY_DIV_LAST = DDIV_W'(DECAY_DIV - 1);

  led_vec_t            led_in_q;
  logic [PDIV_W-1:0]   pwm_div_cnt;
  logic [DDIV_W-1:0]   decay_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_tick;
  logic                decay_tick;

  // Input register: every channel sees the pattern one edge after the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_in_q <= '0;
    end else begin
      led_in_q <= led_in;
    end
  end

  // PWM prescaler and ramp. With PWM_DIV == 1 the prescaler sits at zero and
  // the tick is permanently asserted, so the ramp advances every clock.
  assign pwm_tick = (pwm_div_cnt == PWM_DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_div_cnt <= '0;
      pwm_cnt     <= '0;
    end else begin
      pwm_div_cnt <= pwm_tick ? '0 : (pwm_div_cnt + PDIV_W'(1));
      if (pwm_tick) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
    end
  end

  // Decay prescaler, free-running and unrelated to the PWM ramp.
  assign decay_tick = (decay_cnt == DECAY_DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decay_cnt <= '0;
    end else begin
      decay_cnt <= decay_tick ? '0 : (decay_cnt + DDIV_W'(1));
    end
  end

  // One channel per LED; all share the ramp, the decay strobe and enable.
  for (genvar i = 0; i < LED_COUNT; i++) begin : g_chan
    led_pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (led_in_q[i]),
      .decay_tick (decay_tick),
      .enable     (enable),
      .pwm_cnt    (pwm_cnt),
      .led_out    (led_out[i])
    );
  end

endmodule
